// File: rtl/wb_uart.sv
// wb_uart: Wishbone pipelined slave exposing an 8N1 serial port with
// small TX/RX FIFOs, a programmable baud divisor and polled status flags.
`timescale 1ns/1ps

module wb_uart #(
  parameter int          TX_DEPTH  = 4,
  parameter int          RX_DEPTH  = 4,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_adr,
  input  logic        i_cyc,
  input  logic        i_stb,
  input  logic        i_we,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  output logic        o_ack,
  output logic        o_stall,
  input  logic        i_rxd,
  output logic        o_txd
);

  localparam int TXAW = $clog2(TX_DEPTH);
  localparam int RXAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  logic w_accept, w_txWrite, w_rxRead, w_statusRead, w_divWrite;
  logic [15:0] r_div;

  logic [7:0]    r_txMem [TX_DEPTH];
  logic [TXAW:0] r_txWr, r_txRd;
  logic          w_txEmpty, w_txFull, w_txPush, w_txPop;

  logic [7:0]    r_rxMem [RX_DEPTH];
  logic [RXAW:0] r_rxWr, r_rxRd;
  logic          w_rxEmpty, w_rxFull, w_rxPush, w_rxPop;

  txState_t    r_txState, w_txStateNext;
  logic [15:0] r_txCnt, w_txCntNext;
  logic [2:0]  r_txBit, w_txBitNext;
  logic [7:0]  r_txByte, w_txByteNext;
  logic        w_txdNext;

  rxState_t    r_rxState, w_rxStateNext;
  logic [15:0] r_rxCnt, w_rxCntNext;
  logic [2:0]  r_rxBit, w_rxBitNext;
  logic [7:0]  r_rxByte, w_rxByteNext;
  logic [1:0]  r_rxSync;
  logic        r_rxPrev, w_rxS, w_rxFall, w_rxDone, w_rxPushReq, w_rxFrameSet, w_rxOverSet;
  logic [15:0] w_rxHalf, w_rxHalfM1;
  logic        r_rxOverrun, r_rxFrameErr;
  logic [15:0] w_status;
  logic        w_unused;

  assign w_accept     = i_cyc & i_stb;
  assign w_txWrite    = w_accept &  i_we & (i_adr[1:0] == 2'd0);
  assign w_divWrite   = w_accept &  i_we & (i_adr[1:0] == 2'd2);
  assign w_rxRead     = w_accept & ~i_we & (i_adr[1:0] == 2'd0);
  assign w_statusRead = w_accept & ~i_we & (i_adr[1:0] == 2'd1);
  assign o_stall      = 1'b0;
  assign w_unused     = &{1'b0, i_adr[15:2]};

  assign w_txEmpty = (r_txWr == r_txRd);
  assign w_txFull  = (r_txWr[TXAW] != r_txRd[TXAW]) && (r_txWr[TXAW-1:0] == r_txRd[TXAW-1:0]);
  assign w_txPush  = w_txWrite & (~w_txFull | w_txPop);

  assign w_rxEmpty = (r_rxWr == r_rxRd);
  assign w_rxFull  = (r_rxWr[RXAW] != r_rxRd[RXAW]) && (r_rxWr[RXAW-1:0] == r_rxRd[RXAW-1:0]);
  assign w_rxPop   = w_rxRead & ~w_rxEmpty;
  assign w_rxPush  = w_rxPushReq & (~w_rxFull | w_rxPop);
  assign w_rxOverSet = w_rxPushReq & w_rxFull & ~w_rxPop;

  assign w_status = {11'd0, r_rxFrameErr, r_rxOverrun, ~w_rxEmpty,
                     w_txEmpty & (r_txState == TX_IDLE), w_txFull};

  // Divisor register; a mid-frame write only takes effect at the next bit reload
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_div <= DIV_RESET;
    else if (w_divWrite) r_div <= i_dat;
  end

  // Bus response: one-cycle ack per accepted strobe with registered read data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ack <= 1'b0;
      o_dat <= 16'd0;
    end else begin
      o_ack <= w_accept;
      o_dat <= 16'd0;
      if (w_accept && !i_we) begin
        case (i_adr[1:0])
          2'd0:    o_dat <= w_rxEmpty ? 16'd0 : {8'h00, r_rxMem[r_rxRd[RXAW-1:0]]};
          2'd1:    o_dat <= w_status;
          2'd2:    o_dat <= r_div;
          default: o_dat <= 16'd0;
        endcase
      end
    end
  end

  // TX FIFO storage
  always_ff @(posedge i_clk) begin
    if (w_txPush) r_txMem[r_txWr[TXAW-1:0]] <= i_dat[7:0];
  end

  // TX FIFO pointers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_txWr <= '0;
      r_txRd <= '0;
    end else begin
      if (w_txPush) r_txWr <= r_txWr + 1'b1;
      if (w_txPop)  r_txRd <= r_txRd + 1'b1;
    end
  end

  // Transmitter state register together with its bit timing and data registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_txState <= TX_IDLE;
      r_txCnt   <= 16'd0;
      r_txBit   <= 3'd0;
      r_txByte  <= 8'd0;
    end else begin
      r_txState <= w_txStateNext;
      r_txCnt   <= w_txCntNext;
      r_txBit   <= w_txBitNext;
      r_txByte  <= w_txByteNext;
    end
  end

  // Transmitter next state: every state lasts DIV+1 clocks, FIFO popped on frame start
  always_comb begin
    w_txStateNext = r_txState;
    w_txCntNext   = r_txCnt - 16'd1;
    w_txBitNext   = r_txBit;
    w_txByteNext  = r_txByte;
    w_txPop       = 1'b0;
    case (r_txState)
      TX_IDLE: begin
        w_txCntNext = r_txCnt;
        if (!w_txEmpty) begin
          w_txStateNext = TX_START;
          w_txCntNext   = r_div;
          w_txByteNext  = r_txMem[r_txRd[TXAW-1:0]];
          w_txPop       = 1'b1;
        end
      end
      TX_START: begin
        if (r_txCnt == 16'd0) begin
          w_txStateNext = TX_DATA;
          w_txCntNext   = r_div;
          w_txBitNext   = 3'd0;
        end
      end
      TX_DATA: begin
        if (r_txCnt == 16'd0) begin
          w_txCntNext = r_div;
          if (r_txBit == 3'd7) w_txStateNext = TX_STOP;
          else                 w_txBitNext   = r_txBit + 3'd1;
        end
      end
      default: begin
        if (r_txCnt == 16'd0) begin
          if (!w_txEmpty) begin
            w_txStateNext = TX_START;
            w_txCntNext   = r_div;
            w_txByteNext  = r_txMem[r_txRd[TXAW-1:0]];
            w_txPop       = 1'b1;
          end else begin
            w_txStateNext = TX_IDLE;
          end
        end
      end
    endcase
  end

  // Transmitter output: line level for the state being entered, so txd tracks the state register
  always_comb begin
    case (w_txStateNext)
      TX_START: w_txdNext = 1'b0;
      TX_DATA:  w_txdNext = w_txByteNext[w_txBitNext];
      default:  w_txdNext = 1'b1;
    endcase
  end

  // Registered serial output; reset drives the line idle immediately
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_txd <= 1'b1;
    else       o_txd <= w_txdNext;
  end

  // Two-flop synchroniser for rxd plus a delayed copy for falling-edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rxSync <= 2'b11;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxSync <= {r_rxSync[0], i_rxd};
      r_rxPrev <= w_rxS;
    end
  end

  assign w_rxS      = r_rxSync[1];
  assign w_rxFall   = r_rxPrev & ~w_rxS;
  assign w_rxHalf   = {1'b0, r_div[15:1]} + {15'd0, r_div[0]};
  assign w_rxHalfM1 = (w_rxHalf == 16'd0) ? 16'd0 : w_rxHalf - 16'd1;

  // Receiver state register together with its bit timing and shift registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rxState <= RX_IDLE;
      r_rxCnt   <= 16'd0;
      r_rxBit   <= 3'd0;
      r_rxByte  <= 8'd0;
    end else begin
      r_rxState <= w_rxStateNext;
      r_rxCnt   <= w_rxCntNext;
      r_rxBit   <= w_rxBitNext;
      r_rxByte  <= w_rxByteNext;
    end
  end

  // Receiver next state: half-bit start check, then full-bit samples LSB first
  always_comb begin
    w_rxStateNext = r_rxState;
    w_rxCntNext   = r_rxCnt - 16'd1;
    w_rxBitNext   = r_rxBit;
    w_rxByteNext  = r_rxByte;
    w_rxDone      = 1'b0;
    case (r_rxState)
      RX_IDLE: begin
        w_rxCntNext = r_rxCnt;
        if (w_rxFall) begin
          w_rxStateNext = RX_START;
          w_rxCntNext   = w_rxHalfM1;
        end
      end
      RX_START: begin
        if (r_rxCnt == 16'd0) begin
          if (w_rxS) begin
            w_rxStateNext = RX_IDLE;
          end else begin
            w_rxStateNext = RX_DATA;
            w_rxCntNext   = r_div;
            w_rxBitNext   = 3'd0;
          end
        end
      end
      RX_DATA: begin
        if (r_rxCnt == 16'd0) begin
          w_rxByteNext[r_rxBit] = w_rxS;
          w_rxCntNext = r_div;
          if (r_rxBit == 3'd7) w_rxStateNext = RX_STOP;
          else                 w_rxBitNext   = r_rxBit + 3'd1;
        end
      end
      default: begin
        if (r_rxCnt == 16'd0) begin
          w_rxStateNext = RX_IDLE;
          w_rxDone      = 1'b1;
        end
      end
    endcase
  end

  // Receiver outputs: a good stop bit delivers the byte, a bad one flags a framing error
  always_comb begin
    w_rxPushReq  = w_rxDone &  w_rxS;
    w_rxFrameSet = w_rxDone & ~w_rxS;
  end

  // RX FIFO storage
  always_ff @(posedge i_clk) begin
    if (w_rxPush) r_rxMem[r_rxWr[RXAW-1:0]] <= r_rxByte;
  end

  // RX FIFO pointers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rxWr <= '0;
      r_rxRd <= '0;
    end else begin
      if (w_rxPush) r_rxWr <= r_rxWr + 1'b1;
      if (w_rxPop)  r_rxRd <= r_rxRd + 1'b1;
    end
  end

  // Sticky error flags; a STATUS read clears them but a same-cycle set wins
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rxOverrun  <= 1'b0;
      r_rxFrameErr <= 1'b0;
    end else begin
      if (w_rxOverSet)       r_rxOverrun <= 1'b1;
      else if (w_statusRead) r_rxOverrun <= 1'b0;
      if (w_rxFrameSet)      r_rxFrameErr <= 1'b1;
      else if (w_statusRead) r_rxFrameErr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_uart.sv
// tb_wb_uart: directed bench for wb_uart covering the bus, transmitter and receiver.
`timescale 1ns/1ps

module tb_wb_uart;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] adr;
  logic        cyc, stb, we;
  logic [15:0] datI, datO;
  logic        ack, stall, rxd, txd;

  int checks = 0;
  int errors = 0;

  logic [15:0] rdata;
  logic [7:0]  monQ[$];
  logic [7:0]  monByte;
  logic        monBusy = 1'b0;
  logic        monStopBad = 1'b0;
  int          monCnt = 0;

  wb_uart #(.TX_DEPTH(4), .RX_DEPTH(4), .DIV_RESET(16'd433)) dut (
    .i_clk(clk), .i_rst(rst), .i_adr(adr), .i_cyc(cyc), .i_stb(stb), .i_we(we),
    .i_dat(datI), .o_dat(datO), .o_ack(ack), .o_stall(stall), .i_rxd(rxd), .o_txd(txd)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Line monitor that decodes txd frames assuming a 4-clock bit period
  always @(negedge clk) begin
    if (!monBusy) begin
      if (txd === 1'b0) begin
        monBusy = 1'b1;
        monCnt  = 0;
      end
    end else begin
      monCnt++;
      if (monCnt >= 6 && monCnt <= 34 && (monCnt % 4) == 2) monByte[(monCnt - 6) / 4] = txd;
      if (monCnt == 38) begin
        if (txd !== 1'b1) monStopBad = 1'b1;
        monQ.push_back(monByte);
        monBusy = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One Wishbone transaction; the ack is checked on every access
  task automatic applyStimulus(input logic wrEn, input logic [1:0] a, input logic [15:0] d,
                               output logic [15:0] rd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = wrEn; adr = {14'd0, a}; datI = d;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rd = datO;
    checkOutput("busAck", {15'd0, ack}, 16'h0001);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int bitClk);
    logic [9:0] fr;
    fr = {stopBit, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (bitClk) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  initial begin
    logic [7:0] txByte;
    logic [7:0] expQ[6];
    int polls;

    rst = 1'b1; adr = 16'd0; cyc = 1'b0; stb = 1'b0; we = 1'b0; datI = 16'd0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetTxd", {15'd0, txd}, 16'h0001);
    checkOutput("resetAck", {15'd0, ack}, 16'h0000);
    checkOutput("resetDat", datO, 16'h0000);
    rst = 1'b0;

    applyStimulus(1'b0, 2'd1, 16'd0, rdata);
    checkOutput("resetStatus", rdata, 16'h0002);
    applyStimulus(1'b0, 2'd2, 16'd0, rdata);
    checkOutput("resetDiv", rdata, 16'd433);
    applyStimulus(1'b0, 2'd3, 16'd0, rdata);
    checkOutput("reg3Read", rdata, 16'h0000);

    $display("[TB] transmit 0xA5 with DIV=3");
    applyStimulus(1'b1, 2'd2, 16'd3, rdata);
    applyStimulus(1'b0, 2'd2, 16'd0, rdata);
    checkOutput("divReadback", rdata, 16'h0003);
    txByte = 8'hA5;
    applyStimulus(1'b1, 2'd0, {8'h00, txByte}, rdata);
    checkOutput("txdBeforeStart", {15'd0, txd}, 16'h0001);
    @(negedge clk);
    checkOutput("txdStart", {15'd0, txd}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      checkOutput($sformatf("txdBit%0d", i), {15'd0, txd}, {15'd0, txByte[i]});
    end
    repeat (4) @(negedge clk);
    checkOutput("txdStop", {15'd0, txd}, 16'h0001);
    applyStimulus(1'b0, 2'd1, 16'd0, rdata);
    checkOutput("statusDuringStop", rdata, 16'h0000);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 2'd1, 16'd0, rdata);
    checkOutput("statusAfterStop", rdata, 16'h0002);

    $display("[TB] five back-to-back DATA writes");
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'd0; datI = 16'h0010;
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      checkOutput("burstAck", {15'd0, ack}, 16'h0001);
      datI = 16'h0010 + 16'(k);
    end
    @(negedge clk);
    checkOutput("burstAck", {15'd0, ack}, 16'h0001);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    checkOutput("burstAckDrop", {15'd0, ack}, 16'h0000);
    applyStimulus(1'b0, 2'd1, 16'd0, rdata);
    checkOutput("txFullStatus", rdata, 16'h0001);
    polls = 0;
    do begin
      applyStimulus(1'b0, 2'd1, 16'd0, rdata);
      polls++;
    end while (rdata[1] !== 1'b1 && polls < 400);
    checkOutput("txDrain", rdata, 16'h0002);
    expQ = '{8'hA5, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    checkOutput("txFrameCount", 16'(monQ.size()), 16'd6);
    checkOutput("txStopBits", {15'd0, monStopBad}, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      if (i < monQ.size()) checkOutput($sformatf("txByte%0d", i), {8'h00, monQ[i]}, {8'h00, expQ[i]});
    end

    $display("[TB] receive 0x3C with DIV=7");
    applyStimulus(1'b1, 2'd2, 16'd7, rdata);
    sendFrame(8'h3C, 1'b1, 8);
    applyStimulus(1'b0, 2'd1, 16'd0, rdata);
    checkOutput("rxValid", rdata, 16'h0006);
    applyStimulus(1'b0, 2'd0, 16'd0, rdata);
    checkOutput("rxData3C", rdata, 16'h003C);
    applyStimulus(1'b0, 2'd1, 16'd0, rdata);
    checkOutput("rxValidCleared", rdata, 16'h0002);
    applyStimulus(1'b0, 2'd0, 16'd0, rdata);
    checkOutput("rxEmptyRead", rdata, 16'h0000);

    $display("[TB] five frames without reads");
    for (int i = 1; i <= 5; i++) begin
      sendFrame(8'(i * 8'h11), 1'b1, 8);
      repeat (2) @(negedge clk);
    end
    applyStimulus(1'b0, 2'd1, 16'd0, rdata);
    checkOutput("rxOverrun", rdata, 16'h000E);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 2'd0, 16'd0, rdata);
      checkOutput($sformatf("rxOrder%0d", i), rdata, {8'h00, 8'(i * 8'h11)});
    end
    applyStimulus(1'b0, 2'd1, 16'd0, rdata);
    checkOutput("rxOverrunCleared", rdata, 16'h0002);
    applyStimulus(1'b0, 2'd0, 16'd0, rdata);
    checkOutput("rxDrained", rdata, 16'h0000);

    $display("[TB] framing error and glitch");
    sendFrame(8'h5A, 1'b0, 8);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 2'd1, 16'd0, rdata);
    checkOutput("rxFrameErr", rdata, 16'h0012);
    applyStimulus(1'b0, 2'd1, 16'd0, rdata);
    checkOutput("rxFrameErrCleared", rdata, 16'h0002);
    applyStimulus(1'b0, 2'd0, 16'd0, rdata);
    checkOutput("rxFrameNoPush", rdata, 16'h0000);
    @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(1'b0, 2'd1, 16'd0, rdata);
    checkOutput("rxGlitchStatus", rdata, 16'h0002);
    applyStimulus(1'b0, 2'd0, 16'd0, rdata);
    checkOutput("rxGlitchNoPush", rdata, 16'h0000);

    $display("[TB] reset during a frame");
    applyStimulus(1'b1, 2'd0, 16'h0081, rdata);
    @(negedge clk);
    checkOutput("txdStartBeforeReset", {15'd0, txd}, 16'h0000);
    #2 rst = 1'b1;
    #1 checkOutput("txdAsyncReset", {15'd0, txd}, 16'h0001);
    checkOutput("ackAsyncReset", {15'd0, ack}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 2'd2, 16'd0, rdata);
    checkOutput("divAfterReset", rdata, 16'd433);
    applyStimulus(1'b0, 2'd1, 16'd0, rdata);
    checkOutput("statusAfterReset", rdata, 16'h0002);
    repeat (10) @(negedge clk);
    checkOutput("txdIdleAfterReset", {15'd0, txd}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_uart.md
# wb_uart

Wishbone pipelined slave providing an 8N1 serial port to the J1 CPU; it sits downstream of the Wishbone interconnect on an I/O slave port (5000H region) and returns `ack` exactly one cycle after every accepted strobe. The block holds small TX and RX FIFOs, a programmable baud divisor, and status flags. The CPU polls those flags; the block raises no interrupts.

## Interface
- `TX_DEPTH`, 4: TX FIFO entries; power of 2, ≥2.
- `RX_DEPTH`, 4: RX FIFO entries; power of 2, ≥2.
- `DIV_RESET`, 16'd433: reset value of the divisor register. Bit period is DIV+1 clocks.

- `clk` in 1: system clock. One clock drives the whole block.
- `rst` in 1: reset, asynchronous and active-high.
- `adr` in 16: word address; only `adr[1:0]` is decoded.
- `cyc`, `stb`, `we` in 1 each: Wishbone cycle, strobe and write enable.
- `dat_i` in 16: write data.
- `dat_o` out 16: read data, registered.
- `ack` out 1: registered acknowledge.
- `stall` out 1: tied 0.
- `rxd` in 1: serial input, asynchronous to `clk`.
- `txd` out 1: serial output, registered.

## Operation
- Register map:
  - 0 DATA: a write pushes `dat_i[7:0]` into the TX FIFO. A read pops the RX FIFO and returns {8'h00, byte}.
  - 1 STATUS: read-only. Bit 0 tx_full, bit 1 tx_idle (FIFO empty and transmitter idle), bit 2 rx_valid, bit 3 rx_overrun, bit 4 rx_frame_err. All other bits read 0.
  - 2 DIV: read/write, all 16 bits.
  - 3: reads 0; writes are ignored.
- A strobe is accepted when `cyc & stb`. `ack` and `dat_o` are valid on the following cycle. `ack` is high for exactly one cycle per accepted strobe, including back-to-back strobes.
- Write to DATA while the TX FIFO is full: data is dropped, the write is still acked, and no flag is set.
- Read of DATA while the RX FIFO is empty: returns 16'h0000, nothing is popped, and the read is acked.
- rx_overrun and rx_frame_err are sticky and are cleared by a STATUS read. If a clear and a set fall on the same cycle, the set wins.
- TX FSM, states IDLE → START → DATA → STOP → IDLE (or → START directly if the FIFO is non-empty):
  - Each state lasts DIV+1 clocks.
  - DATA sends 8 bits, LSB first.
  - `txd` is 0 in START and 1 in STOP and IDLE.
  - The FIFO is popped on the IDLE→START transition.
- RX path: `rxd` passes through a 2-flop synchroniser. RX FSM:
  - IDLE: on a synchronised 1→0 edge, go to START.
  - START: wait (DIV+1)>>1 clocks and resample. If the sample is 1, return to IDLE (glitch); if 0, go to DATA.
  - DATA: 8 samples at DIV+1-clock intervals, LSB first.
  - STOP: one sample after DIV+1 clocks.
  - Stop sample = 1: push the byte into the RX FIFO. If the FIFO is full, drop the byte and set rx_overrun.
  - Stop sample = 0: discard the byte and set rx_frame_err.
  - After STOP, return to IDLE.
- DIV write mid-frame: the current bit finishes with the old count. The new value applies at the next bit-counter reload.
- FIFO pointers are log2(DEPTH)+1 bits wide; full/empty are decided by comparing the MSBs.

## Timing
- Reset values:
  - `ack`=0, `dat_o`=0, `txd`=1, DIV=`DIV_RESET`.
  - FIFOs empty, both FSMs in IDLE, sticky flags 0.
  - Synchroniser flops reset to 1.
- Reset mid-frame aborts transmission immediately: `txd` is forced to 1 asynchronously.
- Write latency: DATA write accepted in cycle N, entry visible in the FIFO in N+1. If the transmitter is idle it pops in N+1, and `txd` falls in N+2.
- RX latency: rx_valid rises 2 (synchroniser) + (DIV+1)>>1 + 9×(DIV+1) + 1 clocks after the `rxd` falling edge.
- RX read cycle: pop and data capture happen in the accept cycle. A STATUS read in the next accepted strobe already reflects the pop.
- A push and a pop on the same FIFO in the same cycle: both happen and the count is unchanged. A full FIFO still accepts the push when a pop occurs in the same cycle.

## Test plan
- Reset, then read STATUS → 16'h0002. Read DIV → 16'd433. `txd`=1.
- Write DIV=3, write DATA=8'hA5 → `txd` falls in the second cycle after the accept, then sends bits 1,0,1,0,0,1,0,1 at 4 clocks each, then stop=1. tx_idle returns to 1 after the stop bit.
- Write DATA 5 times back-to-back with DIV=3 and TX_DEPTH=4 → 5 acks on consecutive cycles. tx_full is seen; the 5th byte is dropped only if no pop has yet occurred; the transmitted byte count matches.
- Drive `rxd` with 8'h3C, DIV=7 → rx_valid=1, DATA read returns 16'h003C, rx_valid=0 afterwards. A further DATA read returns 16'h0000.
- Send 5 frames with no reads (RX_DEPTH=4) → rx_overrun=1 and the first 4 bytes are read back in order. A STATUS read clears overrun.
- Frame with stop bit 0 → rx_frame_err=1 and no byte is pushed. A 1-clock low glitch on `rxd` pushes nothing and sets no flag.
